// File: rtl/arbitro_banco_registradores_pkg.sv
// =====================================================================
// arbitro_banco_registradores_pkg : shared states, requester IDs, defaults
// Rev 1.0
// =====================================================================
`default_nettype none

package arbitro_banco_registradores_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int NREG_DEF   = 4;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BULK   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/banco_registradores.sv
// =====================================================================
// banco_registradores : NREG x WIDTH flip-flop bank, one write port
// Rev 1.0
// =====================================================================
`default_nettype none

module banco_registradores
  import arbitro_banco_registradores_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_bank_clear,
  input  logic              i_bank_preset,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [NREG];

  // Addresses at or beyond NREG match no word: writes vanish, reads give 0
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!clear_n || i_bank_clear) begin
        r_mem[i] <= '0;
      end else if (i_bank_preset) begin
        r_mem[i] <= '1;
      end else if (i_we && (i_addr == ADDR_W'(i))) begin
        r_mem[i] <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i_addr == ADDR_W'(i)) begin
        o_rdata = r_mem[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arbitro_banco_registradores.sv
// =====================================================================
// arbitro_banco_registradores : round-robin A/B arbiter for a register bank
// Rev 1.0
// =====================================================================
`default_nettype none

module arbitro_banco_registradores
  import arbitro_banco_registradores_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              cmd_clear,
  input  logic              cmd_preset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_a,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [WIDTH-1:0]  rdata,
  output logic              busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             w_last_grant_nxt;
  logic             r_owner;
  logic             w_owner_nxt;
  logic             r_preset;
  logic             w_preset_nxt;
  logic [WIDTH-1:0] r_rdata;

  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [WIDTH-1:0]  w_sel_wdata;
  logic [WIDTH-1:0]  w_bank_rdata;
  logic              w_bank_we;
  logic              w_bank_clear;
  logic              w_bank_preset;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= REQ_B;
      r_owner      <= REQ_A;
      r_preset     <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_preset     <= w_preset_nxt;
      if (r_state == ST_ACCESS && !w_sel_we) begin
        r_rdata <= w_bank_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_owner_nxt      = r_owner;
    w_preset_nxt     = r_preset;
    gnt_a            = 1'b0;
    gnt_b            = 1'b0;
    ack_a            = 1'b0;
    ack_b            = 1'b0;
    busy             = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        // Bank commands outrank accesses; clear outranks preset
        if (cmd_clear || cmd_preset) begin
          w_state_nxt  = ST_BULK;
          w_preset_nxt = !cmd_clear;
        end else if (req_a && req_b) begin
          w_state_nxt      = ST_ACCESS;
          w_owner_nxt      = ~r_last_grant;
          w_last_grant_nxt = ~r_last_grant;
        end else if (req_a) begin
          w_state_nxt = ST_ACCESS;
          w_owner_nxt = REQ_A;
        end else if (req_b) begin
          w_state_nxt = ST_ACCESS;
          w_owner_nxt = REQ_B;
        end
      end
      ST_BULK: begin
        w_state_nxt = ST_IDLE;
      end
      ST_ACCESS: begin
        w_state_nxt = ST_DONE;
        gnt_a       = (r_owner == REQ_A);
        gnt_b       = (r_owner == REQ_B);
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        ack_a       = (r_owner == REQ_A);
        ack_b       = (r_owner == REQ_B);
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_sel_we      = (r_owner == REQ_A) ? we_a    : we_b;
  assign w_sel_addr    = (r_owner == REQ_A) ? addr_a  : addr_b;
  assign w_sel_wdata   = (r_owner == REQ_A) ? wdata_a : wdata_b;
  assign w_bank_we     = (r_state == ST_ACCESS) && w_sel_we;
  assign w_bank_clear  = (r_state == ST_BULK) && !r_preset;
  assign w_bank_preset = (r_state == ST_BULK) && r_preset;
  assign rdata         = r_rdata;

  banco_registradores #(
    .WIDTH  (WIDTH),
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_banco (
    .clk           (clk),
    .clear_n       (clear_n),
    .i_we          (w_bank_we),
    .i_addr        (w_sel_addr),
    .i_wdata       (w_sel_wdata),
    .i_bank_clear  (w_bank_clear),
    .i_bank_preset (w_bank_preset),
    .o_rdata       (w_bank_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_arbitro_banco_registradores.sv
// =====================================================================
// tb_arbitro_banco_registradores : directed + random check against a
// transaction-level model of the arbiter and bank. Rev 1.0
// =====================================================================
`default_nettype none

module tb_arbitro_banco_registradores;

  localparam int WIDTH  = 8;
  localparam int NREG   = 3;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              clear_n = 1'b0;
  logic              cmd_clear = 1'b0;
  logic              cmd_preset = 1'b0;
  logic              req_a = 1'b0;
  logic              req_b = 1'b0;
  logic              we_a = 1'b0;
  logic              we_b = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0;
  logic [ADDR_W-1:0] addr_b = '0;
  logic [WIDTH-1:0]  wdata_a = '0;
  logic [WIDTH-1:0]  wdata_b = '0;
  logic              gnt_a;
  logic              gnt_b;
  logic              ack_a;
  logic              ack_b;
  logic [WIDTH-1:0]  rdata;
  logic              busy;

  arbitro_banco_registradores #(
    .WIDTH  (WIDTH),
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .cmd_clear  (cmd_clear),
    .cmd_preset (cmd_preset),
    .req_a      (req_a),
    .req_b      (req_b),
    .we_a       (we_a),
    .we_b       (we_b),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .wdata_a    (wdata_a),
    .wdata_b    (wdata_b),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .ack_a      (ack_a),
    .ack_b      (ack_b),
    .rdata      (rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bank contents, round-robin pointer (1 = B), last read
  logic [WIDTH-1:0] m_bank [4];
  logic             m_last;
  logic [WIDTH-1:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bank[i] = '0;
    m_last  = 1'b1;
    m_rdata = '0;
  endtask

  task automatic do_access(input logic ra, input logic wa, input logic [ADDR_W-1:0] aa,
                           input logic [WIDTH-1:0] da, input logic rb, input logic wb,
                           input logic [ADDR_W-1:0] ab, input logic [WIDTH-1:0] db,
                           input logic cmd_mid);
    logic             win;
    logic             w;
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0] d;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    if (ra && rb) begin
      win    = ~m_last;
      m_last = win;
    end else begin
      win = rb;
    end
    tick();
    chk("gnt_a_access", 32'(gnt_a), 32'(!win));
    chk("gnt_b_access", 32'(gnt_b), 32'(win));
    chk("busy_access", 32'(busy), 32'd1);
    chk("ack_access", 32'({ack_a, ack_b}), 32'd0);
    if (cmd_mid) cmd_preset = 1'b1;
    w = win ? wb : wa;
    a = win ? ab : aa;
    d = win ? db : da;
    if (w) begin
      if (32'(a) < NREG) m_bank[a] = d;
    end else begin
      m_rdata = (32'(a) < NREG) ? m_bank[a] : '0;
    end
    tick();
    cmd_preset = 1'b0;
    chk("ack_a_done", 32'(ack_a), 32'(!win));
    chk("ack_b_done", 32'(ack_b), 32'(win));
    chk("gnt_done", 32'({gnt_a, gnt_b}), 32'd0);
    chk("rdata_done", 32'(rdata), 32'(m_rdata));
    tick();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("ack_idle", 32'({ack_a, ack_b}), 32'd0);
  endtask

  task automatic do_bulk(input logic cc, input logic cp, input logic ra, input logic rb);
    cmd_clear = cc; cmd_preset = cp;
    req_a = ra; we_a = 1'b1; addr_a = 2'd0; wdata_a = 8'h5A;
    req_b = rb; we_b = 1'b1; addr_b = 2'd1; wdata_b = 8'hA5;
    tick();
    cmd_clear = 1'b0; cmd_preset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    chk("busy_bulk", 32'(busy), 32'd1);
    chk("gnt_bulk", 32'({gnt_a, gnt_b}), 32'd0);
    chk("ack_bulk", 32'({ack_a, ack_b}), 32'd0);
    for (int i = 0; i < NREG; i++) m_bank[i] = cc ? 8'h00 : 8'hFF;
    tick();
    chk("busy_after_bulk", 32'(busy), 32'd0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) do_access(1'b1, 1'b0, ADDR_W'(i), 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  initial begin
    model_reset();
    // Reset held two cycles with a pending request
    clear_n = 1'b0; req_a = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
      chk("rst_ack", 32'({ack_a, ack_b}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
    end
    clear_n = 1'b1; req_a = 1'b0;
    read_all();

    // A writes then reads addr 2
    do_access(1'b1, 1'b1, 2'd2, 8'hAA, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    do_access(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

    // Tie: A reads addr 1 while B writes 0x55 there, continuously
    for (int k = 0; k < 4; k++)
      do_access(1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 1'b1, 2'd1, 8'h55, 1'b0);

    // Bulk commands, with requests pending to show command priority
    do_bulk(1'b0, 1'b1, 1'b1, 1'b1);
    read_all();
    do_bulk(1'b1, 1'b1, 1'b0, 1'b1);
    read_all();

    // Reset during ACCESS aborts the write
    do_bulk(1'b0, 1'b1, 1'b0, 1'b0);
    req_a = 1'b1; we_a = 1'b1; addr_a = 2'd0; wdata_a = 8'h33; req_b = 1'b0;
    tick();
    chk("midrst_gnt", 32'(gnt_a), 32'd1);
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1; req_a = 1'b0;
    model_reset();
    chk("midrst_ack", 32'({ack_a, ack_b}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    read_all();

    // Out-of-range address 3 with NREG = 3
    do_access(1'b1, 1'b1, 2'd2, 8'h21, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    do_access(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    do_access(1'b1, 1'b1, 2'd3, 8'h77, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    do_access(1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    read_all();

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        logic cc;
        logic cp;
        cc = 1'($urandom_range(0, 1));
        cp = cc ? 1'($urandom_range(0, 1)) : 1'b1;
        do_bulk(cc, cp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        logic ra;
        logic rb;
        ra = 1'($urandom_range(0, 1));
        rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
        do_access(ra, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                  rb, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                  ($urandom_range(0, 7) == 0));
      end
    end
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/arbitro_banco_registradores.md
Name: arbitro_banco_registradores

Overview:
- Controller/arbiter that shares one bank of NREG x WIDTH-bit D-flip-flop registers between two requesters, A and B.
- Serialises single-word read/write accesses with a req/gnt/ack handshake and fair round-robin priority.
- Also sequences bank-wide clear and preset commands.
- Sits between requester logic (e.g. a counter or ALU block) and the register-bank datapath.

Parameters:
- WIDTH, 8, bits per register word.
- NREG, 4, number of registers in the bank.
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NREG.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- clear_n  in  1  reset, synchronous, active-low; one clock, reset is synchronous and active-low.
- cmd_clear  in  1  pulse request: zero every bank register.
- cmd_preset  in  1  pulse request: set every bank register to all ones.
- req_a / req_b  in  1  access request from A / B.
- we_a / we_b  in  1  1 = write, 0 = read.
- addr_a / addr_b  in  ADDR_W  target register.
- wdata_a / wdata_b  in  WIDTH  write data.
- gnt_a / gnt_b  out  1  high during the cycle the access executes.
- ack_a / ack_b  out  1  one-cycle completion pulse.
- rdata  out  WIDTH  read result, valid while ack_x is high after a read.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (clear_n=0 at a rising edge) has priority over everything. It forces:
  - state=IDLE, all bank registers 0x00;
  - gnt_a/b=0, ack_a/b=0, rdata=0, busy=0;
  - last_grant=B, so A wins the first tie.
- Reset mid-operation aborts the access: no write occurs, no ack is issued.
- FSM has four states: IDLE, BULK, ACCESS, DONE.
- IDLE, in priority order:
  - cmd_clear or cmd_preset high -> BULK. Commands are latched; if both are high, clear wins and preset is dropped.
  - Otherwise one req high -> ACCESS for that requester.
  - Both req high -> grant the requester not equal to last_grant, then update last_grant.
  - No request -> stay in IDLE.
- BULK (1 cycle):
  - Whole bank is written 0x00 (clear) or 0xFF (preset) at the end of the cycle.
  - busy=1, no gnt, no ack.
  - Next state: IDLE.
- ACCESS (1 cycle):
  - gnt_x=1 for the granted requester only.
  - Write: bank[addr_x] <= wdata_x at the end of the cycle.
  - Read: rdata <= bank[addr_x] at the end of the cycle.
  - Next state: DONE.
- DONE (1 cycle):
  - ack_x=1; rdata holds the read value (unchanged on a write).
  - Next state: IDLE.
- Latency: req sampled in IDLE at cycle N -> gnt at N+1 -> ack at N+2 -> IDLE at N+3. Minimum 3 cycles per access.
- Back-to-back: a requester keeping req high after ack is re-arbitrated in IDLE. With both requesting continuously, grants alternate A,B,A,B.
- Requester obligations: hold req/we/addr/wdata stable from assertion until ack.
- If req drops during ACCESS, the access still completes and acks; inputs are sampled in the ACCESS cycle.
- Commands arriving outside IDLE are ignored (pulse semantics); requesters must retry when busy=0.
- Out-of-range address (addr >= NREG): write is discarded, read returns 0. The access is still granted and acked.
- rdata retains its last value until the next read completes or reset.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=2'd0, ST_BULK=2'd1, ST_ACCESS=2'd2, ST_DONE=2'd3;
  - requester IDs REQ_A=1'b0, REQ_B=1'b1;
  - WIDTH/NREG defaults.
- Sub-module banco_registradores holds the storage: NREG x WIDTH flip-flops with a single write port (we, addr, wdata), bank_clear, bank_preset, synchronous clear_n, and a combinational read port.
- The arbiter FSM, last_grant pointer, and output registers stay in the top module.

Test Plan:
- Reset: hold clear_n=0 for 2 cycles with req_a=1 -> no gnt/ack; rdata=0; all bank words read back 0x00.
- Write then read by A: write addr=2 data=0xAA, then read addr=2 -> gnt_a at N+1, ack_a at N+2, rdata=0xAA on the read ack; gnt_b/ack_b never asserted.
- Tie fairness: req_a=req_b=1 continuously, 4 accesses -> grant order A,B,A,B, each ack 3 cycles apart; B writing 0x55 to addr=1 is readable by A.
- Bulk commands: cmd_preset pulse -> busy 1 cycle, every address reads 0xFF. Then cmd_clear=cmd_preset=1 together -> every address reads 0x00.
- Mid-op reset: A writes 0x33 to addr=0 with clear_n pulled low in the ACCESS cycle -> no ack_a; addr=0 reads 0x00 after reset.
- Boundary: with NREG=3 and ADDR_W=2, write 0x77 to addr=3 -> acked with no bank change; read addr=3 -> rdata=0x00.
